// File: rtl/mac_scheduler_if.sv
// rtl/mac_scheduler_if.sv - requester, multiplier and result bundle for mac_scheduler
//
// Purpose: groups every non-clock/reset signal of mac_scheduler into one bundle.
// master = the scheduler itself, slave = the environment (front ends, multiplier, consumer).
// Signals:
//   req_valid   per-requester job pending
//   req_pixels  packed pixel vectors, requester r element k at [(r*NUM_INPUTS+k)*PIXEL_WIDTH +: PIXEL_WIDTH]
//   req_weights packed weight vectors, same packing
//   req_grant   one-hot grant pulse, vector captured on that cycle
//   mult_pixel  / mult_weight  operands toward the shared multiplier
//   mult_product               product returned by the multiplier
//   res_valid / res_ready      result handshake
//   res_id / res_data          owner index and dot product
//   busy        scheduler not idle
interface mac_scheduler_if #(
  parameter int NUM_REQ      = 4,
  parameter int ID_WIDTH     = 2,
  parameter int NUM_INPUTS   = 4,
  parameter int PIXEL_WIDTH  = 10,
  parameter int WEIGHT_WIDTH = 19,
  parameter int OUTPUT_WIDTH = 26
);
  logic [NUM_REQ-1:0]                          req_valid;
  logic [NUM_REQ*NUM_INPUTS*PIXEL_WIDTH-1:0]   req_pixels;
  logic [NUM_REQ*NUM_INPUTS*WEIGHT_WIDTH-1:0]  req_weights;
  logic [NUM_REQ-1:0]                          req_grant;
  logic [PIXEL_WIDTH-1:0]                      mult_pixel;
  logic [WEIGHT_WIDTH-1:0]                     mult_weight;
  logic [OUTPUT_WIDTH-1:0]                     mult_product;
  logic                                        res_valid;
  logic [ID_WIDTH-1:0]                         res_id;
  logic [OUTPUT_WIDTH-1:0]                     res_data;
  logic                                        res_ready;
  logic                                        busy;

  modport master (
    input  req_valid, req_pixels, req_weights, mult_product, res_ready,
    output req_grant, mult_pixel, mult_weight, res_valid, res_id, res_data, busy
  );

  modport slave (
    output req_valid, req_pixels, req_weights, mult_product, res_ready,
    input  req_grant, mult_pixel, mult_weight, res_valid, res_id, res_data, busy
  );
endinterface

// File: rtl/mac_scheduler.sv
// rtl/mac_scheduler.sv - round-robin dot-product scheduler around one shared multiplier
//
// Purpose: grants one requester at a time (round-robin), captures its pixel and
// weight vectors, streams them one element per cycle into an external pipelined
// multiplier, accumulates the products as they come back and presents the sum
// with the owner's ID on a valid/ready result port.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  mac_scheduler_if.master (requests, multiplier operands/product, result, busy)
module mac_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int ID_WIDTH     = 2,
  parameter int NUM_INPUTS   = 4,
  parameter int PIXEL_WIDTH  = 10,
  parameter int WEIGHT_WIDTH = 19,
  parameter int OUTPUT_WIDTH = 26,
  parameter int MULT_LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  mac_scheduler_if.master bus
);

  localparam int K_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(NUM_INPUTS - 1);
  localparam int CW = ID_WIDTH + 1;
  localparam logic [ID_WIDTH-1:0] ID_LAST = ID_WIDTH'(NUM_REQ - 1);
  // Output stage of the valid delay line; everything else must be empty to leave DRAIN.
  localparam logic [MULT_LATENCY-1:0] DL_OUT = MULT_LATENCY'(1) << (MULT_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESULT} state_t;

  state_t                   state_q, state_d;
  logic [ID_WIDTH-1:0]      rr_ptr_q;
  logic [ID_WIDTH-1:0]      res_id_q;
  logic [K_W-1:0]           k_q;
  logic [MULT_LATENCY-1:0]  dl_q;
  logic [OUTPUT_WIDTH-1:0]  acc_q;
  logic [PIXEL_WIDTH-1:0]   pix_q [NUM_INPUTS];
  logic [WEIGHT_WIDTH-1:0]  wgt_q [NUM_INPUTS];

  logic                     grant_found;
  logic [ID_WIDTH-1:0]      grant_idx;
  logic [CW-1:0]            cand_w;
  logic                     issuing;
  logic                     take_grant;

  assign issuing    = (state_q == ISSUE);
  assign take_grant = (state_q == IDLE) && grant_found;

  // Round-robin search: first pending requester at or after rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_w      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_w = {1'b0, rr_ptr_q} + CW'(i);
      if (cand_w >= CW'(NUM_REQ)) begin
        cand_w = cand_w - CW'(NUM_REQ);
      end
      if (!grant_found && bus.req_valid[cand_w[ID_WIDTH-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand_w[ID_WIDTH-1:0];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_found) state_d = ISSUE;
      ISSUE:   if (k_q == K_LAST) state_d = DRAIN;
      // Leave once only the output stage may still hold a product: that one is
      // accumulated on this same edge, so RESULT starts with the full sum.
      DRAIN:   if ((dl_q & ~DL_OUT) == '0) state_d = RESULT;
      RESULT:  if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant is gated by rst so it reads 0 while reset is held even if requests are pending.
  always_comb begin
    bus.req_grant = '0;
    if (rst && take_grant) begin
      bus.req_grant[grant_idx] = 1'b1;
    end
  end

  assign bus.mult_pixel  = issuing ? pix_q[k_q] : '0;
  assign bus.mult_weight = issuing ? wgt_q[k_q] : '0;
  assign bus.res_valid   = (state_q == RESULT);
  assign bus.res_id      = res_id_q;
  assign bus.res_data    = acc_q;
  assign bus.busy        = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      res_id_q <= '0;
      k_q      <= '0;
      dl_q     <= '0;
      acc_q    <= '0;
      for (int k = 0; k < NUM_INPUTS; k++) begin
        pix_q[k] <= '0;
        wgt_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      // Delay line mirrors the multiplier pipeline: a 1 marks a real product.
      dl_q    <= MULT_LATENCY'({dl_q, issuing});

      if (take_grant) begin
        rr_ptr_q <= (grant_idx == ID_LAST) ? '0 : grant_idx + ID_WIDTH'(1);
        res_id_q <= grant_idx;
        acc_q    <= '0;
        k_q      <= '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
          pix_q[k] <= bus.req_pixels[(int'(grant_idx) * NUM_INPUTS + k) * PIXEL_WIDTH +: PIXEL_WIDTH];
          wgt_q[k] <= bus.req_weights[(int'(grant_idx) * NUM_INPUTS + k) * WEIGHT_WIDTH +: WEIGHT_WIDTH];
        end
      end else if (dl_q[MULT_LATENCY-1]) begin
        // Modular two's-complement add: overflow wraps.
        acc_q <= acc_q + bus.mult_product;
      end

      if (issuing) begin
        k_q <= (k_q == K_LAST) ? '0 : k_q + K_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mac_scheduler.sv
// tb/tb_mac_scheduler.sv - self-checking bench for mac_scheduler
//
// Purpose: drives requester jobs, models the shared pipelined multiplier and
// compares grants, latency and dot products against a reference model.
// Ports: none (top-level bench).
module tb_mac_scheduler;
  localparam int NR = 4;
  localparam int IDW = 2;
  localparam int NI = 4;
  localparam int PW = 10;
  localparam int WW = 19;
  localparam int OW = 26;
  localparam int ML = 2;
  localparam int JOB_LAT = NI + ML + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mac_scheduler_if #(.NUM_REQ(NR), .ID_WIDTH(IDW), .NUM_INPUTS(NI), .PIXEL_WIDTH(PW),
                     .WEIGHT_WIDTH(WW), .OUTPUT_WIDTH(OW)) bus ();

  mac_scheduler #(.NUM_REQ(NR), .ID_WIDTH(IDW), .NUM_INPUTS(NI), .PIXEL_WIDTH(PW),
                  .WEIGHT_WIDTH(WW), .OUTPUT_WIDTH(OW), .MULT_LATENCY(ML)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Multiplier stand-in: not reset, so stale products survive a scheduler reset.
  function automatic logic [OW-1:0] mult_fn(input logic [PW-1:0] p, input logic [WW-1:0] w);
    longint prod;
    prod = longint'($signed(p)) * longint'($signed(w));
    return OW'(prod);
  endfunction

  logic [OW-1:0] mult_pipe [ML];
  always @(posedge clk) begin
    mult_pipe[0] <= mult_fn(bus.mult_pixel, bus.mult_weight);
    for (int i = 1; i < ML; i++) mult_pipe[i] <= mult_pipe[i-1];
  end
  assign bus.mult_product = mult_pipe[ML-1];

  // Reference model
  logic signed [PW-1:0] m_pix [NR][NI];
  logic signed [WW-1:0] m_wt  [NR][NI];
  int rr_model = 0;

  function automatic logic [OW-1:0] exp_sum(input int r);
    longint s;
    s = 0;
    for (int k = 0; k < NI; k++) s += longint'(m_pix[r][k]) * longint'(m_wt[r][k]);
    return OW'(s);
  endfunction

  function automatic int exp_grant(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) begin
      if (v[(rr_model + i) % NR]) return (rr_model + i) % NR;
    end
    return -1;
  endfunction

  function automatic int oh_idx(input logic [NR-1:0] v);
    if ($countones(v) != 1) return -1;
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic load_vectors;
    for (int r = 0; r < NR; r++) begin
      for (int k = 0; k < NI; k++) begin
        bus.req_pixels[(r*NI+k)*PW +: PW]  = m_pix[r][k];
        bus.req_weights[(r*NI+k)*WW +: WW] = m_wt[r][k];
      end
    end
  endtask

  task automatic randomize_vectors(input bit nonzero);
    for (int r = 0; r < NR; r++) begin
      for (int k = 0; k < NI; k++) begin
        m_pix[r][k] = PW'($urandom);
        m_wt[r][k]  = WW'($urandom);
        if (nonzero) begin
          m_pix[r][k] = PW'($urandom_range(1, 500));
          m_wt[r][k]  = WW'($urandom_range(1, 200000));
        end
      end
    end
    load_vectors();
  endtask

  // Drives one job (called at edge+1ns, DUT idle); reports what the DUT did.
  task automatic do_job(input logic [NR-1:0] vmask, input int ready_delay,
                        output logic [NR-1:0] gvec, output int lat,
                        output logic [OW-1:0] data, output int id);
    int n;
    gvec = '0; lat = -1; data = '0; id = -1;
    bus.req_valid = vmask;
    #1;
    n = 0;
    while (bus.req_grant == '0 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    gvec = bus.req_grant;
    if (gvec == '0) begin
      bus.req_valid = '0;
      return;
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    n = 1;
    while (!bus.res_valid && n < 30) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.res_valid) return;
    lat = n; data = bus.res_data; id = int'(bus.res_id);
    repeat (ready_delay) begin @(posedge clk); #1; end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    bus.req_valid = '1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.req_grant !== '0) $display("FAIL reset_grant: got %b want 0", bus.req_grant); else passed++;
    total++; if (bus.mult_pixel !== '0) $display("FAIL reset_pixel: got %h want 0", bus.mult_pixel); else passed++;
    total++; if (bus.mult_weight !== '0) $display("FAIL reset_weight: got %h want 0", bus.mult_weight); else passed++;
    total++; if (bus.res_valid !== 1'b0) $display("FAIL reset_res_valid: got %b want 0", bus.res_valid); else passed++;
    total++; if (bus.res_data !== '0) $display("FAIL reset_res_data: got %h want 0", bus.res_data); else passed++;
    total++; if (bus.res_id !== '0) $display("FAIL reset_res_id: got %h want 0", bus.res_id); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else passed++;
    bus.req_valid = '0;
    rst = 1'b1;
    rr_model = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    logic [NR-1:0] g; int lat; logic [OW-1:0] d; int id;
    for (int k = 0; k < NI; k++) begin
      m_pix[0][k] = PW'(k + 1);
      m_wt[0][k]  = WW'(19'h20000);
    end
    load_vectors();
    do_job(4'b0001, 0, g, lat, d, id);
    rr_model = 1;
    total++; if (g !== 4'b0001) $display("FAIL single_grant: got %b want 0001", g); else passed++;
    total++; if (lat !== JOB_LAT) $display("FAIL single_latency: got %0d want %0d", lat, JOB_LAT); else passed++;
    total++; if (d !== 26'h0140000) $display("FAIL single_data: got %h want 0140000", d); else passed++;
    total++; if (id !== 0) $display("FAIL single_id: got %0d want 0", id); else passed++;
  endtask

  task automatic test_signed;
    logic [NR-1:0] g; int lat; logic [OW-1:0] d; int id;
    for (int k = 0; k < NI; k++) begin
      m_pix[2][k] = '0;
      m_wt[2][k]  = '0;
    end
    m_pix[2][0] = 10'h3FD;
    m_wt[2][0]  = 19'h10000;
    load_vectors();
    do_job(4'b0100, 1, g, lat, d, id);
    rr_model = 3;
    total++; if (g !== 4'b0100) $display("FAIL signed_grant: got %b want 0100", g); else passed++;
    total++; if (d !== 26'h3FD0000) $display("FAIL signed_data: got %h want 3FD0000", d); else passed++;
    total++; if (id !== 2) $display("FAIL signed_id: got %0d want 2", id); else passed++;
  endtask

  task automatic test_overflow;
    logic [NR-1:0] g; int lat; logic [OW-1:0] d; int id;
    for (int k = 0; k < NI; k++) begin
      m_pix[3][k] = PW'(100);
      m_wt[3][k]  = WW'(19'h3FFFF);
    end
    load_vectors();
    do_job(4'b1000, 0, g, lat, d, id);
    rr_model = 0;
    total++; if (d !== exp_sum(3)) $display("FAIL overflow_data: got %h want %h", d, exp_sum(3)); else passed++;
    total++; if (d !== 26'h23FFE70) $display("FAIL overflow_const: got %h want 23FFE70", d); else passed++;
  endtask

  task automatic test_round_robin;
    int gid [5];
    int gcyc [5];
    int gi, n, overlap, resmis, rj;
    rst = 1'b0; #1; rst = 1'b1;
    rr_model = 0;
    @(posedge clk); #1;
    randomize_vectors(1'b1);
    bus.res_ready = 1'b1;
    bus.req_valid = '1;
    #1;
    gi = 0; n = 0; overlap = 0; resmis = 0; rj = 0;
    while (gi < 5 && n < 100) begin
      if (bus.req_grant != '0) begin
        gid[gi] = oh_idx(bus.req_grant); gcyc[gi] = cyc; gi++;
      end
      if (bus.res_valid) begin
        if (bus.mult_pixel != '0 || bus.mult_weight != '0) overlap++;
        if (bus.res_data !== exp_sum(rj % NR) || int'(bus.res_id) != rj % NR) resmis++;
        rj++;
      end
      @(posedge clk); #1; n++;
    end
    bus.req_valid = '0;
    n = 0;
    while (bus.busy && n < 30) begin
      if (bus.res_valid && (bus.mult_pixel != '0 || bus.mult_weight != '0)) overlap++;
      @(posedge clk); #1; n++;
    end
    bus.res_ready = 1'b0;
    rr_model = 1;
    total++; if (gi !== 5) $display("FAIL rr_grant_count: got %0d want 5", gi); else passed++;
    for (int i = 0; i < 5; i++) begin
      total++; if (i < gi && gid[i] !== i % NR) $display("FAIL rr_order[%0d]: got %0d want %0d", i, gid[i], i % NR); else passed++;
    end
    for (int i = 1; i < 5; i++) begin
      total++; if (i < gi && gcyc[i] - gcyc[i-1] !== 8) $display("FAIL rr_spacing[%0d]: got %0d want 8", i, gcyc[i] - gcyc[i-1]); else passed++;
    end
    total++; if (overlap !== 0) $display("FAIL rr_overlap: got %0d want 0", overlap); else passed++;
    total++; if (rj < 4 || resmis !== 0) $display("FAIL rr_results: got %0d bad of %0d want 0 bad of >=4", resmis, rj); else passed++;
  endtask

  task automatic test_back_pressure;
    logic [NR-1:0] g; int lat; logic [OW-1:0] d; int id;
    logic [OW-1:0] d0; int i0, n, bad, gbad;
    randomize_vectors(1'b0);
    bus.req_valid = 4'b0010;
    #1;
    total++; if (bus.req_grant !== 4'b0010) $display("FAIL bp_first_grant: got %b want 0010", bus.req_grant); else passed++;
    rr_model = 2;
    @(posedge clk); #1;
    bus.req_valid = 4'b1000;
    n = 0; gbad = 0;
    while (!bus.res_valid && n < 30) begin
      if (bus.req_grant != '0) gbad++;
      @(posedge clk); #1; n++;
    end
    d0 = bus.res_data; i0 = int'(bus.res_id);
    bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (!bus.res_valid || bus.res_data !== d0 || int'(bus.res_id) != i0) bad++;
      if (bus.req_grant != '0) gbad++;
    end
    bus.res_ready = 1'b1;
    #1;
    if (bus.req_grant != '0) gbad++;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    g = bus.req_grant;
    total++; if (d0 !== exp_sum(1)) $display("FAIL bp_data: got %h want %h", d0, exp_sum(1)); else passed++;
    total++; if (i0 !== 1) $display("FAIL bp_id: got %0d want 1", i0); else passed++;
    total++; if (bad !== 0) $display("FAIL bp_stable: got %0d unstable cycles want 0", bad); else passed++;
    total++; if (gbad !== 0) $display("FAIL bp_no_grant: got %0d grant cycles want 0", gbad); else passed++;
    total++; if (oh_idx(g) !== exp_grant(4'b1000)) $display("FAIL bp_next_grant: got %b want idx %0d", g, exp_grant(4'b1000)); else passed++;
    rr_model = 0;
    // Finish requester 3's job via the standard driver path (grant already taken).
    @(posedge clk); #1;
    bus.req_valid = '0;
    n = 0;
    while (!bus.res_valid && n < 30) begin @(posedge clk); #1; n++; end
    d = bus.res_data; id = int'(bus.res_id);
    bus.res_ready = 1'b1; @(posedge clk); #1; bus.res_ready = 1'b0;
    lat = n;
    total++; if (d !== exp_sum(3) || id !== 3) $display("FAIL bp_second_result: got %h/%0d want %h/3", d, id, exp_sum(3)); else passed++;
  endtask

  task automatic test_reset_mid_issue;
    logic [NR-1:0] g; int lat; logic [OW-1:0] d; int id;
    int r, r2;
    randomize_vectors(1'b1);
    r = int'($urandom_range(0, NR - 1));
    bus.req_valid = NR'(1) << r;
    #1;
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++; if (bus.mult_pixel !== m_pix[r][2]) $display("FAIL mid_k2_pixel: got %h want %h", bus.mult_pixel, m_pix[r][2]); else passed++;
    rst = 1'b0;
    #1;
    total++; if (bus.mult_pixel !== '0 || bus.mult_weight !== '0) $display("FAIL mid_reset_mult: got %h/%h want 0/0", bus.mult_pixel, bus.mult_weight); else passed++;
    total++; if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0) $display("FAIL mid_reset_ctrl: got busy %b valid %b want 0 0", bus.busy, bus.res_valid); else passed++;
    total++; if (bus.res_data !== '0 || bus.req_grant !== '0) $display("FAIL mid_reset_data: got %h grant %b want 0", bus.res_data, bus.req_grant); else passed++;
    rst = 1'b1;
    rr_model = 0;
    randomize_vectors(1'b1);
    r2 = int'($urandom_range(0, NR - 1));
    do_job(NR'(1) << r2, 0, g, lat, d, id);
    rr_model = (r2 + 1) % NR;
    total++; if (oh_idx(g) !== r2) $display("FAIL mid_new_grant: got %b want idx %0d", g, r2); else passed++;
    total++; if (d !== exp_sum(r2)) $display("FAIL mid_new_data: got %h want %h", d, exp_sum(r2)); else passed++;
  endtask

  task automatic test_random;
    logic [NR-1:0] g; int lat; logic [OW-1:0] d; int id;
    logic [NR-1:0] vm; int eg;
    for (int it = 0; it < 12; it++) begin
      randomize_vectors(1'b0);
      vm = NR'($urandom_range(1, (1 << NR) - 1));
      eg = exp_grant(vm);
      do_job(vm, int'($urandom_range(0, 3)), g, lat, d, id);
      rr_model = (eg + 1) % NR;
      total++; if (oh_idx(g) !== eg) $display("FAIL rand_grant[%0d]: got %b want idx %0d", it, g, eg); else passed++;
      total++; if (lat !== JOB_LAT) $display("FAIL rand_latency[%0d]: got %0d want %0d", it, lat, JOB_LAT); else passed++;
      total++; if (id !== eg || d !== exp_sum(eg)) $display("FAIL rand_result[%0d]: got %h/%0d want %h/%0d", it, d, id, exp_sum(eg), eg); else passed++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.req_valid   = '0;
    bus.req_pixels  = '0;
    bus.req_weights = '0;
    bus.res_ready   = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_signed();
    test_overflow();
    test_round_robin();
    test_back_pressure();
    test_reset_mid_issue();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
